// File: rtl/self_attention_ctrl_if.sv
// Handshake bundle between the multi-head top and one self-attention head controller.
// master = multi-head top / datapath side, slave = the controller.
interface self_attention_ctrl_if #(
  parameter int NUM_W    = 2,
  parameter int NUM_ROWS = 8
);
  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       en_Qn_KnT;
  logic                       rst_n_Qn_KnT;
  logic                       reset_acc_Qn_KnT;
  logic                       acc_done_Qn_KnT;
  logic                       out_valid_Qn_KnT;
  logic                       rst_n_b2r;
  logic                       slice_done_b2r;
  logic                       out_ready_b2r;
  logic                       softmax_en;
  logic [NUM_ROWS-1:0]        softmax_valid;
  logic [NUM_ROWS-1:0]        rst_n_softmax;
  logic [NUM_W*NUM_ROWS-1:0]  done_softmax;

  modport master (
    output start,
    output acc_done_Qn_KnT,
    output slice_done_b2r,
    output out_ready_b2r,
    output done_softmax,
    input  busy,
    input  done,
    input  en_Qn_KnT,
    input  rst_n_Qn_KnT,
    input  reset_acc_Qn_KnT,
    input  out_valid_Qn_KnT,
    input  rst_n_b2r,
    input  softmax_en,
    input  softmax_valid,
    input  rst_n_softmax
  );

  modport slave (
    input  start,
    input  acc_done_Qn_KnT,
    input  slice_done_b2r,
    input  out_ready_b2r,
    input  done_softmax,
    output busy,
    output done,
    output en_Qn_KnT,
    output rst_n_Qn_KnT,
    output reset_acc_Qn_KnT,
    output out_valid_Qn_KnT,
    output rst_n_b2r,
    output softmax_en,
    output softmax_valid,
    output rst_n_softmax
  );
endinterface

// File: rtl/self_attention_ctrl.sv
// Sequencer for one self-attention head: matmul, shift, B2R conversion and softmax rows.
// All outputs come straight from flops; every state change happens on the rising clk edge.
module self_attention_ctrl #(
  parameter int NUM_W         = 2,
  parameter int NUM_ROWS      = 8,
  parameter int TILES_PER_ROW = 4,
  parameter int RST_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  self_attention_ctrl_if.slave bus
);

  localparam int RCW = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
  localparam int RW  = (NUM_ROWS      > 1) ? $clog2(NUM_ROWS)      : 1;
  localparam int TW  = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;

  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [RCW-1:0] RST_ONE   = RCW'(1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(NUM_ROWS - 1);
  localparam logic [RW-1:0]  ROW_ONE   = RW'(1);
  localparam logic [TW-1:0]  TILE_LAST = TW'(TILES_PER_ROW - 1);
  localparam logic [TW-1:0]  TILE_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_MM    = 3'd2,
    S_SHIFT = 3'd3,
    S_B2R   = 3'd4,
    S_SMX   = 3'd5,
    S_WAIT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t                state_q;
  logic [RCW-1:0]        rst_cnt_q;
  logic [RW-1:0]         row_q;
  logic [TW-1:0]         tile_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  en_mm_q;
  logic                  rst_n_mm_q;
  logic                  reset_acc_q;
  logic                  out_valid_q;
  logic                  rst_n_b2r_q;
  logic                  softmax_en_q;
  logic [NUM_ROWS-1:0]   softmax_valid_q;
  logic [NUM_ROWS-1:0]   rst_n_softmax_q;

  logic [NUM_ROWS-1:0]   row_onehot_d;
  logic                  all_done_s;

  // Decode the current softmax row into the tile-valid pattern for the next cycle.
  always_comb begin
    row_onehot_d        = {NUM_ROWS{1'b0}};
    row_onehot_d[row_q] = 1'b1;
    all_done_s          = &bus.done_softmax;
  end

  // Head sequencer: state, counters and all registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rst_cnt_q       <= {RCW{1'b0}};
      row_q           <= {RW{1'b0}};
      tile_q          <= {TW{1'b0}};
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      en_mm_q         <= 1'b0;
      rst_n_mm_q      <= 1'b0;
      reset_acc_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      rst_n_b2r_q     <= 1'b0;
      softmax_en_q    <= 1'b0;
      softmax_valid_q <= {NUM_ROWS{1'b0}};
      rst_n_softmax_q <= {NUM_ROWS{1'b0}};
    end else begin
      // Pulse-type outputs fall back to zero unless a state re-asserts them.
      done_q          <= 1'b0;
      reset_acc_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      softmax_valid_q <= {NUM_ROWS{1'b0}};
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_RST;
            busy_q    <= 1'b1;
            rst_cnt_q <= {RCW{1'b0}};
          end else begin
            busy_q    <= 1'b0;
          end
        end
        S_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q         <= S_MM;
            rst_cnt_q       <= {RCW{1'b0}};
            en_mm_q         <= 1'b1;
            reset_acc_q     <= 1'b1;
            rst_n_mm_q      <= 1'b1;
            rst_n_b2r_q     <= 1'b1;
            rst_n_softmax_q <= {NUM_ROWS{1'b1}};
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_ONE;
          end
        end
        S_MM: begin
          if (bus.acc_done_Qn_KnT) begin
            state_q     <= S_SHIFT;
            en_mm_q     <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            en_mm_q     <= 1'b1;
          end
        end
        S_SHIFT: begin
          state_q <= S_B2R;
        end
        S_B2R: begin
          if (bus.out_ready_b2r) begin
            state_q      <= S_SMX;
            softmax_en_q <= 1'b1;
            row_q        <= {RW{1'b0}};
            tile_q       <= {TW{1'b0}};
          end else begin
            softmax_en_q <= 1'b0;
          end
        end
        S_SMX: begin
          if (bus.slice_done_b2r) begin
            softmax_valid_q <= row_onehot_d;
            if (tile_q == TILE_LAST) begin
              tile_q <= {TW{1'b0}};
              if (row_q == ROW_LAST) begin
                state_q <= S_WAIT;
                row_q   <= {RW{1'b0}};
              end else begin
                row_q   <= row_q + ROW_ONE;
              end
            end else begin
              tile_q <= tile_q + TILE_ONE;
            end
          end else begin
            tile_q <= tile_q;
          end
        end
        S_WAIT: begin
          if (all_done_s) begin
            state_q         <= S_DONE;
            done_q          <= 1'b1;
            softmax_en_q    <= 1'b0;
            rst_n_mm_q      <= 1'b0;
            rst_n_b2r_q     <= 1'b0;
            rst_n_softmax_q <= {NUM_ROWS{1'b0}};
          end else begin
            softmax_en_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q         <= S_IDLE;
          busy_q          <= 1'b0;
          en_mm_q         <= 1'b0;
          rst_n_mm_q      <= 1'b0;
          rst_n_b2r_q     <= 1'b0;
          softmax_en_q    <= 1'b0;
          rst_n_softmax_q <= {NUM_ROWS{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.en_Qn_KnT        = en_mm_q;
  assign bus.rst_n_Qn_KnT     = rst_n_mm_q;
  assign bus.reset_acc_Qn_KnT = reset_acc_q;
  assign bus.out_valid_Qn_KnT = out_valid_q;
  assign bus.rst_n_b2r        = rst_n_b2r_q;
  assign bus.softmax_en       = softmax_en_q;
  assign bus.softmax_valid    = softmax_valid_q;
  assign bus.rst_n_softmax    = rst_n_softmax_q;

endmodule

// File: tb/tb_self_attention_ctrl.sv
// Directed self-checking bench for self_attention_ctrl (NUM_W=2, NUM_ROWS=8, TILES=4, RST_CYCLES=2).
module tb_self_attention_ctrl;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  self_attention_ctrl_if #(.NUM_W(2), .NUM_ROWS(8)) bus ();

  self_attention_ctrl #(
    .NUM_W(2), .NUM_ROWS(8), .TILES_PER_ROW(4), .RST_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it; outputs then show that edge's result.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_smx();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.acc_done_Qn_KnT = 1'b1;
    tick();
    bus.acc_done_Qn_KnT = 1'b0;
    tick();
    bus.out_ready_b2r = 1'b1;
    tick();
    bus.out_ready_b2r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.en_Qn_KnT !== 1'b0) begin failed++; $display("FAIL reset_en got %b want 0", bus.en_Qn_KnT); end
    tests++; if (bus.rst_n_Qn_KnT !== 1'b0) begin failed++; $display("FAIL reset_rstn_mm got %b want 0", bus.rst_n_Qn_KnT); end
    tests++; if (bus.reset_acc_Qn_KnT !== 1'b0) begin failed++; $display("FAIL reset_acc got %b want 0", bus.reset_acc_Qn_KnT); end
    tests++; if (bus.out_valid_Qn_KnT !== 1'b0) begin failed++; $display("FAIL reset_outvalid got %b want 0", bus.out_valid_Qn_KnT); end
    tests++; if (bus.rst_n_b2r !== 1'b0) begin failed++; $display("FAIL reset_rstn_b2r got %b want 0", bus.rst_n_b2r); end
    tests++; if (bus.softmax_en !== 1'b0) begin failed++; $display("FAIL reset_smx_en got %b want 0", bus.softmax_en); end
    tests++; if (bus.softmax_valid !== 8'h00) begin failed++; $display("FAIL reset_smx_valid got %h want 00", bus.softmax_valid); end
    tests++; if (bus.rst_n_softmax !== 8'h00) begin failed++; $display("FAIL reset_rstn_smx got %h want 00", bus.rst_n_softmax); end
    rst = 1'b0;
    tick();
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_matmul();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin failed++; $display("FAIL mm_busy_t1 got %b want 1", bus.busy); end
    tests++; if (bus.rst_n_Qn_KnT !== 1'b0) begin failed++; $display("FAIL mm_rstn_t1 got %b want 0", bus.rst_n_Qn_KnT); end
    tick();
    tests++; if (bus.rst_n_Qn_KnT !== 1'b0) begin failed++; $display("FAIL mm_rstn_t2 got %b want 0", bus.rst_n_Qn_KnT); end
    tests++; if (bus.en_Qn_KnT !== 1'b0) begin failed++; $display("FAIL mm_en_t2 got %b want 0", bus.en_Qn_KnT); end
    tick();
    tests++; if (bus.rst_n_Qn_KnT !== 1'b1) begin failed++; $display("FAIL mm_rstn_t3 got %b want 1", bus.rst_n_Qn_KnT); end
    tests++; if (bus.reset_acc_Qn_KnT !== 1'b1) begin failed++; $display("FAIL mm_acc_t3 got %b want 1", bus.reset_acc_Qn_KnT); end
    tests++; if (bus.en_Qn_KnT !== 1'b1) begin failed++; $display("FAIL mm_en_t3 got %b want 1", bus.en_Qn_KnT); end
    tests++; if (bus.rst_n_b2r !== 1'b1) begin failed++; $display("FAIL mm_rstn_b2r got %b want 1", bus.rst_n_b2r); end
    tests++; if (bus.rst_n_softmax !== 8'hFF) begin failed++; $display("FAIL mm_rstn_smx got %h want ff", bus.rst_n_softmax); end
    // Slices arriving before softmax starts must not advance the row counter.
    bus.slice_done_b2r = 1'b1;
    tick();
    bus.slice_done_b2r = 1'b0;
    tests++; if (bus.reset_acc_Qn_KnT !== 1'b0) begin failed++; $display("FAIL mm_acc_t4 got %b want 0", bus.reset_acc_Qn_KnT); end
    tests++; if (bus.softmax_valid !== 8'h00) begin failed++; $display("FAIL mm_stray_slice got %h want 00", bus.softmax_valid); end
    tick();
    tests++; if (bus.en_Qn_KnT !== 1'b1) begin failed++; $display("FAIL mm_en_t5 got %b want 1", bus.en_Qn_KnT); end
    bus.acc_done_Qn_KnT = 1'b1;
    tick();
    bus.acc_done_Qn_KnT = 1'b0;
    tests++; if (bus.out_valid_Qn_KnT !== 1'b1) begin failed++; $display("FAIL shift_pulse got %b want 1", bus.out_valid_Qn_KnT); end
    tests++; if (bus.en_Qn_KnT !== 1'b0) begin failed++; $display("FAIL shift_en got %b want 0", bus.en_Qn_KnT); end
    tick();
    tests++; if (bus.out_valid_Qn_KnT !== 1'b0) begin failed++; $display("FAIL shift_pulse_end got %b want 0", bus.out_valid_Qn_KnT); end
    tick();
    tests++; if (bus.softmax_en !== 1'b0) begin failed++; $display("FAIL b2r_wait_en got %b want 0", bus.softmax_en); end
    bus.out_ready_b2r = 1'b1;
    tick();
    bus.out_ready_b2r = 1'b0;
    tests++; if (bus.softmax_en !== 1'b1) begin failed++; $display("FAIL smx_en got %b want 1", bus.softmax_en); end
  endtask

  // Slices 1..12 with an idle cycle after each: rows 0..2.
  task automatic test_softmax_rows();
    logic [7:0] exp_v;
    for (int p = 1; p <= 12; p++) begin
      exp_v = 8'h01 << ((p - 1) / 4);
      bus.slice_done_b2r = 1'b1;
      tick();
      bus.slice_done_b2r = 1'b0;
      tests++; if (bus.softmax_valid !== exp_v) begin failed++; $display("FAIL row_valid p%0d got %h want %h", p, bus.softmax_valid, exp_v); end
      tick();
      tests++; if (bus.softmax_valid !== 8'h00) begin failed++; $display("FAIL row_gap p%0d got %h want 00", p, bus.softmax_valid); end
    end
  endtask

  // Slices 13..20 on consecutive cycles across the row 3 -> 4 boundary.
  task automatic test_back_to_back();
    logic [7:0] exp_v;
    bus.slice_done_b2r = 1'b1;
    for (int p = 13; p <= 20; p++) begin
      exp_v = 8'h01 << ((p - 1) / 4);
      tick();
      tests++; if (bus.softmax_valid !== exp_v) begin failed++; $display("FAIL b2b_valid p%0d got %h want %h", p, bus.softmax_valid, exp_v); end
    end
    bus.slice_done_b2r = 1'b0;
    tick();
    tests++; if (bus.softmax_valid !== 8'h00) begin failed++; $display("FAIL b2b_idle got %h want 00", bus.softmax_valid); end
  endtask

  // Slices 21..32, then the controller must sit in the wait state.
  task automatic test_softmax_tail();
    logic [7:0] exp_v;
    for (int p = 21; p <= 32; p++) begin
      exp_v = 8'h01 << ((p - 1) / 4);
      bus.slice_done_b2r = 1'b1;
      tick();
      bus.slice_done_b2r = 1'b0;
      tests++; if (bus.softmax_valid !== exp_v) begin failed++; $display("FAIL tail_valid p%0d got %h want %h", p, bus.softmax_valid, exp_v); end
      if (p < 32) tick();
    end
    // Extra slice after the last row must be ignored.
    bus.slice_done_b2r = 1'b1;
    tick();
    bus.slice_done_b2r = 1'b0;
    tests++; if (bus.softmax_valid !== 8'h00) begin failed++; $display("FAIL wait_valid got %h want 00", bus.softmax_valid); end
    tests++; if (bus.softmax_en !== 1'b1) begin failed++; $display("FAIL wait_smx_en got %b want 1", bus.softmax_en); end
    tick();
    tests++; if (bus.softmax_valid !== 8'h00) begin failed++; $display("FAIL wait_valid2 got %h want 00", bus.softmax_valid); end
  endtask

  task automatic test_done();
    bus.done_softmax = 16'hFFFE;
    tick();
    tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL done_partial got %b want 0", bus.done); end
    tick();
    tests++; if (bus.busy !== 1'b1) begin failed++; $display("FAIL done_partial_busy got %b want 1", bus.busy); end
    bus.done_softmax = 16'hFFFF;
    tick();
    bus.done_softmax = 16'h0000;
    tests++; if (bus.done !== 1'b1) begin failed++; $display("FAIL done_pulse got %b want 1", bus.done); end
    tests++; if (bus.softmax_en !== 1'b0) begin failed++; $display("FAIL done_smx_en got %b want 0", bus.softmax_en); end
    tests++; if (bus.rst_n_softmax !== 8'h00) begin failed++; $display("FAIL done_rstn_smx got %h want 00", bus.rst_n_softmax); end
    tests++; if (bus.rst_n_b2r !== 1'b0) begin failed++; $display("FAIL done_rstn_b2r got %b want 0", bus.rst_n_b2r); end
    tests++; if (bus.rst_n_Qn_KnT !== 1'b0) begin failed++; $display("FAIL done_rstn_mm got %b want 0", bus.rst_n_Qn_KnT); end
    tick();
    tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL done_once got %b want 0", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL done_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_abort_and_ignore();
    run_to_smx();
    bus.slice_done_b2r = 1'b1;
    repeat (21) tick();
    bus.slice_done_b2r = 1'b0;
    tests++; if (bus.softmax_valid !== 8'h20) begin failed++; $display("FAIL abort_row5 got %h want 20", bus.softmax_valid); end
    rst = 1'b1;
    bus.slice_done_b2r = 1'b1;
    tick();
    rst = 1'b0;
    bus.slice_done_b2r = 1'b0;
    tests++; if (bus.softmax_valid !== 8'h00) begin failed++; $display("FAIL abort_valid got %h want 00", bus.softmax_valid); end
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    tests++; if (bus.softmax_en !== 1'b0) begin failed++; $display("FAIL abort_smx_en got %b want 0", bus.softmax_en); end
    tests++; if (bus.rst_n_softmax !== 8'h00) begin failed++; $display("FAIL abort_rstn_smx got %h want 00", bus.rst_n_softmax); end
    // New run; a start while busy in the matmul phase must not restart it.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tests++; if (bus.en_Qn_KnT !== 1'b1) begin failed++; $display("FAIL ign_mm_en got %b want 1", bus.en_Qn_KnT); end
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    tests++; if (bus.rst_n_Qn_KnT !== 1'b1) begin failed++; $display("FAIL ign_rstn got %b want 1", bus.rst_n_Qn_KnT); end
    tests++; if (bus.reset_acc_Qn_KnT !== 1'b0) begin failed++; $display("FAIL ign_acc got %b want 0", bus.reset_acc_Qn_KnT); end
    tests++; if (bus.en_Qn_KnT !== 1'b1) begin failed++; $display("FAIL ign_en got %b want 1", bus.en_Qn_KnT); end
    bus.acc_done_Qn_KnT = 1'b1;
    tick();
    bus.acc_done_Qn_KnT = 1'b0;
    tests++; if (bus.out_valid_Qn_KnT !== 1'b1) begin failed++; $display("FAIL ign_shift got %b want 1", bus.out_valid_Qn_KnT); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL final_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    tests                = 0;
    failed               = 0;
    rst                  = 1'b1;
    bus.start            = 1'b0;
    bus.acc_done_Qn_KnT  = 1'b0;
    bus.slice_done_b2r   = 1'b0;
    bus.out_ready_b2r    = 1'b0;
    bus.done_softmax     = 16'h0000;
    test_reset();
    test_matmul();
    test_softmax_rows();
    test_back_to_back();
    test_softmax_tail();
    test_done();
    test_abort_and_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
